memory_arbiter: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/link_register.sv | 40 ++++
 rtl/memory_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_memory_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: data word, RAM handshake state, arbiter FSM
// states and the data-side operation kinds.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IREQ = 2'd1,
        DREQ = 2'd2,
        RESP = 2'd3
    } arbiter_state_t;

    // Data-side operation latched at the start of a request
    typedef enum logic [1:0] {
        OP_LW = 2'd0,
        OP_SW = 2'd1,
        OP_LL = 2'd2,
        OP_SC = 2'd3
    } data_op_t;

endpackage

// File: rtl/link_register.sv
// Load-linked reservation: a valid bit plus the linked word address.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   i_set      LL completed: mark valid and capture i_addr
//   i_clr      SC completed or plain store hit the linked address
//   i_addr     address captured on i_set
//   o_valid    reservation is held
//   o_addr     linked address
import cpu_types_pkg::*;

module link_register (
    input  logic  CLK,
    input  logic  RST,
    input  logic  i_set,
    input  logic  i_clr,
    input  word_t i_addr,
    output logic  o_valid,
    output word_t o_addr
);

    logic  r_valid;
    word_t r_addr;

    // Set wins over clear; the arbiter never raises both together
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_set) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetch and data accesses onto a single RAM port.
// Data requests win over fetches. Every completed access produces a
// one-cycle ihit/dhit pulse in RESP, then the FSM returns to IDLE.
// Optional feature macro: LLSC_EN adds load-linked/store-conditional
// via a link_register instance; without it datomic is ignored.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   iREN, iaddr / iload, ihit   instruction fetch request / response
//   dREN, dWEN, daddr, dstore   data request (dWEN wins if both set)
//   datomic                     marks dREN as LL and dWEN as SC
//   dload, dhit                 data response (SC result under LLSC_EN)
//   ramREN, ramWEN, ramaddr,    RAM request port
//   ramstore
//   ramload, ramstate           RAM response and handshake state
//   stall_count                 cycles spent in IREQ/DREQ since reset
import cpu_types_pkg::*;

module memory_arbiter (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      ihit,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  logic      datomic,
    output word_t     dload,
    output logic      dhit,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output word_t     stall_count
);

    arbiter_state_t r_state;
    word_t          r_iload;
    word_t          r_dload;
    logic           r_ihit;
    logic           r_dhit;
    logic           r_ramREN;
    logic           r_ramWEN;
    word_t          r_ramaddr;
    word_t          r_ramstore;
    word_t          r_stall_count;

    logic w_d_req;
    logic w_req_live;
    logic w_done;

    assign w_d_req    = dREN | dWEN;
    // The requester that owns the current wait must keep its enable high
    assign w_req_live = (r_state == IREQ) ? iREN : w_d_req;
    assign w_done     = ((r_state == IREQ) || (r_state == DREQ)) &&
                        w_req_live && (ramstate == ACCESS);

`ifdef LLSC_EN
    data_op_t r_op;
    data_op_t w_new_op;
    logic     w_link_valid;
    word_t    w_link_addr;
    logic     w_link_set;
    logic     w_link_clr;
    logic     w_sc_fail;

    always_comb begin
        w_new_op = OP_LW;
        if (dWEN)
            w_new_op = datomic ? OP_SC : OP_SW;
        else if (dREN)
            w_new_op = datomic ? OP_LL : OP_LW;
    end

    // SC without a matching reservation completes without touching RAM
    assign w_sc_fail  = (w_new_op == OP_SC) &&
                        !(w_link_valid && (w_link_addr == daddr));
    assign w_link_set = w_done && (r_state == DREQ) && (r_op == OP_LL);
    assign w_link_clr = w_done && (r_state == DREQ) &&
                        ((r_op == OP_SC) ||
                         ((r_op == OP_SW) && (r_ramaddr == w_link_addr)));

    link_register u_link_register (
        .CLK     (CLK),
        .RST     (RST),
        .i_set   (w_link_set),
        .i_clr   (w_link_clr),
        .i_addr  (r_ramaddr),
        .o_valid (w_link_valid),
        .o_addr  (w_link_addr)
    );
`else
    logic w_unused_datomic;
    assign w_unused_datomic = datomic;
`endif

    // Arbiter FSM; RAM outputs are set on entry to IREQ/DREQ so they are
    // valid in the first wait cycle, and cleared on every exit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_iload       <= '0;
            r_dload       <= '0;
            r_ihit        <= 1'b0;
            r_dhit        <= 1'b0;
            r_ramREN      <= 1'b0;
            r_ramWEN      <= 1'b0;
            r_ramaddr     <= '0;
            r_ramstore    <= '0;
            r_stall_count <= '0;
`ifdef LLSC_EN
            r_op          <= OP_LW;
`endif
        end else begin
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_d_req) begin
`ifdef LLSC_EN
                        r_op <= w_new_op;
                        if (w_sc_fail) begin
                            r_state <= RESP;
                            r_dhit  <= 1'b1;
                            r_dload <= '0;
                        end else begin
                            r_state    <= DREQ;
                            r_ramREN   <= ~dWEN;
                            r_ramWEN   <= dWEN;
                            r_ramaddr  <= daddr;
                            r_ramstore <= dstore;
                        end
`else
                        r_state    <= DREQ;
                        r_ramREN   <= ~dWEN;
                        r_ramWEN   <= dWEN;
                        r_ramaddr  <= daddr;
                        r_ramstore <= dstore;
`endif
                    end else if (iREN) begin
                        r_state    <= IREQ;
                        r_ramREN   <= 1'b1;
                        r_ramWEN   <= 1'b0;
                        r_ramaddr  <= iaddr;
                        r_ramstore <= '0;
                    end
                end
                IREQ, DREQ: begin
                    r_stall_count <= r_stall_count + 32'd1;
                    if (!w_req_live || w_done) begin
                        r_ramREN   <= 1'b0;
                        r_ramWEN   <= 1'b0;
                        r_ramaddr  <= '0;
                        r_ramstore <= '0;
                    end
                    if (!w_req_live) begin
                        r_state <= IDLE;
                    end else if (w_done) begin
                        r_state <= RESP;
                        if (r_state == IREQ) begin
                            r_iload <= ramload;
                            r_ihit  <= 1'b1;
                        end else begin
`ifdef LLSC_EN
                            r_dload <= (r_op == OP_SC) ? 32'd1 : ramload;
`else
                            r_dload <= ramload;
`endif
                            r_dhit  <= 1'b1;
                        end
                    end
                    // BUSY, FREE and ERROR: hold the request and retry
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign iload       = r_iload;
    assign ihit        = r_ihit;
    assign dload       = r_dload;
    assign dhit        = r_dhit;
    assign ramREN      = r_ramREN;
    assign ramWEN      = r_ramWEN;
    assign ramaddr     = r_ramaddr;
    assign ramstore    = r_ramstore;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter: fetch, data priority, wait
// states, abort, optional LL/SC (LLSC_EN) and mid-request reset.
import cpu_types_pkg::*;

module tb_memory_arbiter;

    logic      CLK;
    logic      RST;
    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      ihit;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      datomic;
    word_t     dload;
    logic      dhit;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    word_t     stall_count;

    int checks = 0;
    int errors = 0;

    memory_arbiter dut (
        .CLK         (CLK),
        .RST         (RST),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .iload       (iload),
        .ihit        (ihit),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .datomic     (datomic),
        .dload       (dload),
        .dhit        (dhit),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate),
        .stall_count (stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; datomic = 1'b0; ramload = '0; ramstate = FREE;
        tick();
        tick();
        RST = 1'b0;

        // Reset state
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_dhit", 32'(dhit), 32'd0);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        chk("rst_iload", iload, 32'd0);

        // Minimum-latency fetch
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        chk("f_ramREN", 32'(ramREN), 32'd1);
        chk("f_ramaddr", ramaddr, 32'h40);
        chk("f_ihit_early", 32'(ihit), 32'd0);
        ramstate = ACCESS; ramload = 32'h8C010004;
        tick();
        chk("f_ihit", 32'(ihit), 32'd1);
        chk("f_iload", iload, 32'h8C010004);
        chk("f_ramREN_off", 32'(ramREN), 32'd0);
        chk("f_stall", stall_count, 32'd1);
        iREN = 1'b0; ramstate = FREE; ramload = '0;
        tick();
        chk("f_ihit_clr", 32'(ihit), 32'd0);
        chk("f_iload_hold", iload, 32'h8C010004);

        // Simultaneous fetch and load: data first
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
        tick();
        chk("p_d_ramREN", 32'(ramREN), 32'd1);
        chk("p_d_ramaddr", ramaddr, 32'h100);
        ramstate = ACCESS; ramload = 32'h11111111;
        tick();
        chk("p_dhit", 32'(dhit), 32'd1);
        chk("p_ihit_excl", 32'(ihit), 32'd0);
        chk("p_dload", dload, 32'h11111111);
        dREN = 1'b0; ramstate = FREE;
        tick();
        tick();
        chk("p_i_ramaddr", ramaddr, 32'h44);
        chk("p_i_ramREN", 32'(ramREN), 32'd1);
        ramstate = ACCESS; ramload = 32'h22222222;
        tick();
        chk("p_ihit", 32'(ihit), 32'd1);
        chk("p_dhit_excl", 32'(dhit), 32'd0);
        chk("p_iload", iload, 32'h22222222);
        chk("p_dload_hold", dload, 32'h11111111);
        chk("p_stall", stall_count, 32'd3);
        iREN = 1'b0; ramstate = FREE;
        tick();

        // Store with three BUSY cycles
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramstate = BUSY;
        tick();
        chk("w_ramstore", ramstore, 32'hDEADBEEF);
        chk("w_ramREN", 32'(ramREN), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w_ramWEN_%0d", i), 32'(ramWEN), 32'd1);
            chk($sformatf("w_dhit_wait_%0d", i), 32'(dhit), 32'd0);
            if (i == 3) ramstate = ACCESS;
            tick();
        end
        chk("w_dhit", 32'(dhit), 32'd1);
        chk("w_ramWEN_off", 32'(ramWEN), 32'd0);
        chk("w_stall", stall_count, 32'd7);
        dWEN = 1'b0; ramstate = FREE;
        tick();
        chk("w_dhit_once", 32'(dhit), 32'd0);

        // ERROR never completes; then fetch dropped before ACCESS aborts
        iREN = 1'b1; iaddr = 32'h80; ramstate = ERROR; ramload = 32'h33333333;
        tick();
        tick();
        chk("e_ihit", 32'(ihit), 32'd0);
        chk("e_ramREN", 32'(ramREN), 32'd1);
        iREN = 1'b0; ramstate = ACCESS;
        tick();
        chk("a_ihit", 32'(ihit), 32'd0);
        chk("a_ramREN", 32'(ramREN), 32'd0);
        ramstate = FREE;
        tick();
        chk("a_ihit_after", 32'(ihit), 32'd0);
        chk("a_iload_hold", iload, 32'h22222222);
        chk("a_stall", stall_count, 32'd9);

        // Load + store with equal read/write enables is a write
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h240; dstore = 32'h5;
        tick();
        chk("rw_ramWEN", 32'(ramWEN), 32'd1);
        chk("rw_ramREN", 32'(ramREN), 32'd0);
        ramstate = ACCESS;
        tick();
        dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        tick();

`ifdef LLSC_EN
        // LL then SC to the same address succeeds
        dREN = 1'b1; datomic = 1'b1; daddr = 32'h300;
        tick();
        ramstate = ACCESS; ramload = 32'h55;
        tick();
        chk("ll_dhit", 32'(dhit), 32'd1);
        dREN = 1'b0; datomic = 1'b0; ramstate = FREE;
        tick();
        dWEN = 1'b1; datomic = 1'b1; daddr = 32'h300; dstore = 32'h77;
        tick();
        chk("sc_ramWEN", 32'(ramWEN), 32'd1);
        ramstate = ACCESS;
        tick();
        chk("sc_dhit", 32'(dhit), 32'd1);
        chk("sc_dload", dload, 32'd1);
        dWEN = 1'b0; datomic = 1'b0; ramstate = FREE;
        tick();
        // LL, plain SW to the link, SC fails without touching RAM
        dREN = 1'b1; datomic = 1'b1;
        tick();
        ramstate = ACCESS;
        tick();
        dREN = 1'b0; datomic = 1'b0; ramstate = FREE;
        tick();
        dWEN = 1'b1; dstore = 32'h88;
        tick();
        ramstate = ACCESS;
        tick();
        dWEN = 1'b0; ramstate = FREE;
        tick();
        dWEN = 1'b1; datomic = 1'b1; dstore = 32'h99;
        tick();
        chk("scf_ramWEN", 32'(ramWEN), 32'd0);
        chk("scf_dhit", 32'(dhit), 32'd1);
        chk("scf_dload", dload, 32'd0);
        dWEN = 1'b0; datomic = 1'b0;
        tick();
`endif

        // Reset in the middle of a data request
        dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        tick();
        chk("r_ramREN_pre", 32'(ramREN), 32'd1);
        RST = 1'b1; ramstate = ACCESS; ramload = 32'h44444444;
        tick();
        chk("r_ramREN", 32'(ramREN), 32'd0);
        chk("r_ramWEN", 32'(ramWEN), 32'd0);
        chk("r_dhit", 32'(dhit), 32'd0);
        chk("r_stall", stall_count, 32'd0);
        chk("r_dload", dload, 32'd0);
        chk("r_iload", iload, 32'd0);
        RST = 1'b0; dREN = 1'b0; ramstate = FREE;
        tick();
        chk("r_dhit_after", 32'(dhit), 32'd0);
        chk("r_stall_after", stall_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
